// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the iterative round sequencer.
package aes_round_sequencer_pkg;

   localparam int unsigned AES_BLOCK_W = 128;
   localparam int unsigned AES_NR_128  = 10;
   localparam int unsigned AES_NR_192  = 12;
   localparam int unsigned AES_NR_256  = 14;
   localparam int unsigned RK_IDX_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } st_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as x^254 (product of x^2..x^128), then the affine transform; 0 maps to 0x63.
   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / round-key / block-out handshake bundle between the AES core and its neighbours.
interface aes_round_sequencer_if
   import aes_round_sequencer_pkg::*;
#(
   parameter int unsigned RK_IDX_W = RK_IDX_W_DEF
);
   logic                   in_valid;
   logic                   in_ready;
   logic [AES_BLOCK_W-1:0] in_block;
   logic [RK_IDX_W-1:0]    rk_idx;
   logic [AES_BLOCK_W-1:0] rk_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [AES_BLOCK_W-1:0] out_block;
   logic                   busy;

   modport master (
      output in_valid, in_block, rk_data, out_ready,
      input  in_ready, rk_idx, out_valid, out_block, busy
   );

   modport slave (
      input  in_valid, in_block, rk_data, out_ready,
      output in_ready, rk_idx, out_valid, out_block, busy
   );
endinterface

// File: rtl/aes_round_sequencer_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
   import aes_round_sequencer_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] state_in,
   input  logic [AES_BLOCK_W-1:0] rk,
   input  logic                   final_rnd,
   output logic [AES_BLOCK_W-1:0] state_out
);
   logic [7:0]  sb [16];
   logic [7:0]  sr [16];
   logic [7:0]  mc [16];
   logic [31:0] col;

   // Byte i = row (i%4), column (i/4); row r rotates left by r columns.
   always_comb begin
      sb        = '{default: '0};
      sr        = '{default: '0};
      mc        = '{default: '0};
      col       = '0;
      state_out = '0;
      for (int i = 0; i < 16; i++) sb[i] = aes_sbox(state_in[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[4*c+r] = sb[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         col = mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
         {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} = col;
      end
      for (int i = 0; i < 16; i++)
         state_out[127-8*i -: 8] = (final_rnd ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
   end
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: one round per clock over NR rounds, keys fetched by index.
module aes_round_sequencer
   import aes_round_sequencer_pkg::*;
#(
   parameter int unsigned NR       = AES_NR_128,
   parameter int unsigned RK_IDX_W = RK_IDX_W_DEF
)(
   input logic                  clk,
   input logic                  rst,
   aes_round_sequencer_if.slave bus
);
   st_e                    st, st_nx;
   logic [RK_IDX_W-1:0]    rnd, rnd_nx;
   logic [AES_BLOCK_W-1:0] state_q, state_nx, round_out;
   logic                   last_rnd;

   assign last_rnd = (rnd == RK_IDX_W'(NR));

   aes_round_comb u_round (
      .state_in  (state_q),
      .rk        (bus.rk_data),
      .final_rnd (last_rnd),
      .state_out (round_out)
   );

   // Next-state: accept only from IDLE, so in_valid elsewhere is simply ignored.
   always_comb begin
      st_nx    = st;
      rnd_nx   = rnd;
      state_nx = state_q;
      case (st)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_nx = bus.in_block ^ bus.rk_data;
               rnd_nx   = RK_IDX_W'(1);
               st_nx    = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_nx = round_out;
            if (last_rnd) st_nx  = ST_DONE;
            else          rnd_nx = rnd + RK_IDX_W'(1);
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               st_nx  = ST_IDLE;
               rnd_nx = '0;
            end
         end
         default: begin
            st_nx  = ST_IDLE;
            rnd_nx = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the FSM register.
   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= ST_IDLE;
         rnd           <= '0;
         state_q       <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_block <= '0;
         bus.rk_idx    <= '0;
         bus.busy      <= 1'b0;
      end else begin
         st            <= st_nx;
         rnd           <= rnd_nx;
         state_q       <= state_nx;
         bus.in_ready  <= (st_nx == ST_IDLE);
         bus.out_valid <= (st_nx == ST_DONE);
         bus.busy      <= (st_nx != ST_IDLE);
         bus.rk_idx    <= (st_nx == ST_ROUND) ? rnd_nx : '0;
         if (st_nx == ST_DONE && st != ST_DONE) bus.out_block <= state_nx;
      end
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: FIPS-197 vectors, latency trace, backpressure, reset, back-to-back.
module tb_aes_round_sequencer;
   import aes_round_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   aes_round_sequencer_if #(.RK_IDX_W(4)) bus ();

   aes_round_sequencer #(.NR(10), .RK_IDX_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]   sbox_t [256];
   logic [127:0] rk_a [16];
   logic [127:0] rk_b [16];
   logic         key_sel;
   logic [127:0] sb_q [$];

   assign bus.rk_data = key_sel ? rk_b[bus.rk_idx] : rk_a[bus.rk_idx];

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && bmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_t[x] = s;
      end
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      {w[0], w[1], w[2], w[3]} = key;
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t = t ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [127:0] exp;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 128'(sb_q.size()), 128'd1);
      end else begin
         exp = sb_q.pop_front();
         check(tag, bus.out_block, exp);
      end
   endtask

   // Accept one block from IDLE, wait (bounded) for the result and complete the output handshake.
   task automatic run_one(input string tag, input logic [127:0] pt, input logic [127:0] ct);
      bit got;
      check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
      bus.in_valid = 1'b1;
      bus.in_block = pt;
      sb_q.push_back(ct);
      @(negedge clk);
      bus.in_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (bus.out_valid) got = 1'b1;
         else @(negedge clk);
      end
      check({tag, "_out_valid_seen"}, 128'(got), 128'd1);
      bus.out_ready = 1'b1;
      pop_check({tag, "_ct"});
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] held;
      int n_acc, n_out;
      int acc_cyc [2];

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_block  = '0;
      bus.out_ready = 1'b0;
      key_sel = 1'b0;
      build_sbox();
      for (int r = 0; r < 16; r++) begin
         rk_a[r] = (r <= 10) ? round_key(KEY_B, r) : '0;
         rk_b[r] = (r <= 10) ? round_key(KEY_C, r) : '0;
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  128'(bus.in_ready),  128'd1);
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_out_block", bus.out_block,       128'd0);
      check("rst_rk_idx",    128'(bus.rk_idx),    128'd0);
      check("rst_busy",      128'(bus.busy),      128'd0);
      rst = 1'b0;
      @(negedge clk);

      // App.B vector with cycle-by-cycle index/busy/valid trace, then held in DONE.
      bus.in_valid = 1'b1;
      bus.in_block = PT_B;
      sb_q.push_back(CT_B);
      check("trace_c0_rk_idx",   128'(bus.rk_idx),   128'd0);
      check("trace_c0_in_ready", 128'(bus.in_ready), 128'd1);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         check($sformatf("trace_c%0d_rk_idx", c),    128'(bus.rk_idx),    128'((c <= 10) ? c : 0));
         check($sformatf("trace_c%0d_busy", c),      128'(bus.busy),      128'd1);
         check($sformatf("trace_c%0d_out_valid", c), 128'(bus.out_valid), 128'((c == 11) ? 1 : 0));
      end
      held = bus.out_block;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d_out_valid", k), 128'(bus.out_valid), 128'd1);
         check($sformatf("bp%0d_in_ready", k),  128'(bus.in_ready),  128'd0);
         check($sformatf("bp%0d_out_block", k), bus.out_block,       held);
         bus.in_valid = (k == 2);
         bus.in_block = 128'hdeadbeef_00000000_cafef00d_12345678;
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      pop_check("appb_ct");
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_release_in_ready",  128'(bus.in_ready),  128'd1);
      check("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
      check("bp_release_busy",      128'(bus.busy),      128'd0);

      // Reset at round 5 discards the block; a fresh vector then encrypts normally.
      bus.in_valid = 1'b1;
      bus.in_block = PT_B;
      sb_q.push_back(CT_B);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      check("midrst_rk_idx_pre", 128'(bus.rk_idx), 128'd5);
      rst = 1'b1;
      void'(sb_q.pop_front());
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready",  128'(bus.in_ready),  128'd1);
      check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
      check("midrst_rk_idx",    128'(bus.rk_idx),    128'd0);
      check("midrst_out_block", bus.out_block,       128'd0);
      check("midrst_busy",      128'(bus.busy),      128'd0);
      @(negedge clk);
      key_sel = 1'b1;
      run_one("post_rst", PT_C, CT_C);

      // Back-to-back with in_valid and out_ready held high.
      bus.in_valid  = 1'b1;
      bus.in_block  = PT_C;
      bus.out_ready = 1'b1;
      n_acc = 0;
      n_out = 0;
      acc_cyc[0] = 0;
      acc_cyc[1] = 0;
      for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
         if (n_acc >= 2) bus.in_valid = 1'b0;
         if (bus.in_valid && bus.in_ready) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            sb_q.push_back(CT_C);
         end
         if (bus.out_valid) begin
            pop_check($sformatf("b2b_ct%0d", n_out));
            n_out++;
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("b2b_outputs", 128'(n_out), 128'd2);
      check("b2b_accepts", 128'(n_acc), 128'd2);
      check("b2b_interval", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
      check("sb_drained", 128'(sb_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
